// File: rtl/l2_cacheline_adaptor_pkg.sv
// cache_mux_types: shared types and constants for the L2 cacheline adaptor
//   adaptor_state_t : burst adaptor FSM states
//   ADAPTOR_BEATS   : memory beats per cache line
//   AD_S_OFFSET     : log2 of line bytes
//   AD_BURST_WIDTH  : memory beat width in bits
//   AD_LINE_WIDTH   : cache line width in bits
package cache_mux_types;
    typedef enum logic [1:0] {ad_idle, ad_read, ad_write, ad_done} adaptor_state_t;
    localparam int ADAPTOR_BEATS  = 4;
    localparam int AD_S_OFFSET    = 5;
    localparam int AD_BURST_WIDTH = 64;
    localparam int AD_LINE_WIDTH  = 8 * (2 ** AD_S_OFFSET);
endpackage

// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor: converts one 256-bit L2 line read/writeback into a 4-beat 64-bit memory burst
//   clk        : clock, all state on posedge
//   rst        : asynchronous active-low reset
//   address_i  : L2 line address (latched on acceptance)
//   line_i     : L2 writeback line (latched on write acceptance)
//   read_i     : L2 line-read request, held until resp_o
//   write_i    : L2 writeback request, held until resp_o
//   line_o     : assembled read line, holds last completed read
//   resp_o     : one-cycle completion pulse
//   address_o  : line-aligned burst address, stable for the whole burst
//   burst_i    : memory read beat
//   burst_o    : memory write beat
//   read_o     : burst read request
//   write_o    : burst write request
//   resp_i     : memory beat valid/accepted, one per beat
module l2_cacheline_adaptor
    import cache_mux_types::*;
#(
    parameter int s_offset    = AD_S_OFFSET,
    parameter int burst_width = AD_BURST_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  address_i,
    input  logic [8*(2**s_offset)-1:0]   line_i,
    input  logic                         read_i,
    input  logic                         write_i,
    output logic [8*(2**s_offset)-1:0]   line_o,
    output logic                         resp_o,
    output logic [31:0]                  address_o,
    input  logic [burst_width-1:0]       burst_i,
    output logic [burst_width-1:0]       burst_o,
    output logic                         read_o,
    output logic                         write_o,
    input  logic                         resp_i
);
    localparam int s_line    = 8 * (2 ** s_offset);
    localparam int num_beats = s_line / burst_width;
    localparam int cw        = $clog2(num_beats);
    localparam logic [cw-1:0] last_beat = cw'(num_beats - 1);

    adaptor_state_t  state, next_state;
    logic [cw-1:0]   count;
    logic [s_line-1:0] wbuf;

    always_comb begin
        next_state = state;
        case (state)
            ad_idle:  next_state = read_i ? ad_read : (write_i ? ad_write : ad_idle);
            ad_read:  next_state = (resp_i && count == last_beat) ? ad_done : ad_read;
            ad_write: next_state = (resp_i && count == last_beat) ? ad_done : ad_write;
            default:  next_state = ad_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ad_idle;
            count     <= '0;
            wbuf      <= '0;
            line_o    <= '0;
            address_o <= '0;
        end else begin
            state <= next_state;
            case (state)
                ad_idle: begin
                    if (read_i || write_i) begin
                        address_o <= {address_i[31:s_offset], {s_offset{1'b0}}};
                        count     <= '0;
                    end
                    if (!read_i && write_i)
                        wbuf <= line_i;
                end
                ad_read: begin
                    if (resp_i) begin
                        line_o[int'(count)*burst_width +: burst_width] <= burst_i;
                        count <= count + 1'b1;
                    end
                end
                ad_write: begin
                    if (resp_i)
                        count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode purely from registered state/count/buffer, never from inputs.
    assign read_o  = (state == ad_read);
    assign write_o = (state == ad_write);
    assign resp_o  = (state == ad_done);
    assign burst_o = (state == ad_write) ? wbuf[int'(count)*burst_width +: burst_width] : '0;
endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb_l2_cacheline_adaptor: scoreboard bench for the L2 cacheline adaptor
module tb_l2_cacheline_adaptor;
    logic         clk = 0;
    logic         rst = 0;
    logic [31:0]  address_i = '0;
    logic [255:0] line_i = '0;
    logic         read_i = 0;
    logic         write_i = 0;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 0;

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_line[$];
    logic [63:0]  exp_burst[$];
    logic [255:0] cur_line = '0;

    l2_cacheline_adaptor dut (
        .clk(clk), .rst(rst), .address_i(address_i), .line_i(line_i),
        .read_i(read_i), .write_i(write_i), .line_o(line_o), .resp_o(resp_o),
        .address_o(address_o), .burst_i(burst_i), .burst_o(burst_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected values whenever the DUT presents a completion or a write beat.
    always @(negedge clk) begin
        if (rst) begin
            if (read_i && write_i) begin
                checks++;
                errors++;
                $display("FAIL req_conflict actual read_i=1 write_i=1 required exclusive");
            end
            if (resp_o) begin
                if (exp_line.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual resp_o=1 required 0");
                end else
                    chk("resp_line", line_o, exp_line.pop_front());
            end
            if (write_o && resp_i) begin
                if (exp_burst.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual burst_o=%h required none", burst_o);
                end else
                    chk("write_beat", {192'b0, burst_o}, {192'b0, exp_burst.pop_front()});
            end
        end
    end

    // Issues a read; memory answers one cycle after seeing read_o, with resp_i following pat.
    // Returns in DONE with read_i still high.
    task automatic do_read(input logic [31:0] a, input logic [255:0] ln, input logic [15:0] pat, input int exp_edges);
        int k;
        int p;
        int edges;
        k = 0;
        p = 0;
        exp_line.push_back(ln);
        address_i = a;
        read_i = 1;
        tick();
        address_i = ~a;
        chk("read_o_start", {255'b0, read_o}, 256'd1);
        chk("read_addr", {224'b0, address_o}, {224'b0, a[31:5], 5'b0});
        tick();
        edges = 1;
        while (k < 4 && edges < 40) begin
            resp_i  = (p < 16) ? pat[p] : 1'b1;
            burst_i = resp_i ? ln[k*64 +: 64] : ~ln[k*64 +: 64];
            if (resp_i) k++;
            p++;
            tick();
            edges++;
        end
        resp_i = 0;
        burst_i = '0;
        chk("read_done_resp", {255'b0, resp_o}, 256'd1);
        chk("read_o_dropped", {255'b0, read_o}, 256'd0);
        chk("read_addr_held", {224'b0, address_o}, {224'b0, a[31:5], 5'b0});
        if (exp_edges > 0) chk("read_latency", 256'(edges), 256'(exp_edges));
        cur_line = ln;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] ln);
        for (int i = 0; i < 4; i++) exp_burst.push_back(ln[i*64 +: 64]);
        exp_line.push_back(cur_line);
        address_i = a;
        line_i = ln;
        write_i = 1;
        tick();
        line_i = ~ln;
        address_i = ~a;
        chk("write_o_start", {255'b0, write_o}, 256'd1);
        chk("write_addr", {224'b0, address_o}, {224'b0, a[31:5], 5'b0});
        tick();
        resp_i = 1;
        for (int i = 0; i < 4; i++) tick();
        resp_i = 0;
        chk("write_o_dropped", {255'b0, write_o}, 256'd0);
        chk("write_done_resp", {255'b0, resp_o}, 256'd1);
        write_i = 0;
        tick();
        chk("write_line_kept", line_o, cur_line);
    endtask

    initial begin
        logic [255:0] l1, l2, l3, l4;
        l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        l2 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        l3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA, 64'hDEAD_BEEF_CAFE_F00D};
        l4 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};

        tick();
        tick();
        chk("rst_line_o", line_o, '0);
        chk("rst_resp_o", {255'b0, resp_o}, '0);
        chk("rst_read_o", {255'b0, read_o}, '0);
        chk("rst_write_o", {255'b0, write_o}, '0);
        chk("rst_address_o", {224'b0, address_o}, '0);
        chk("rst_burst_o", {192'b0, burst_o}, '0);
        rst = 1;
        tick();

        // 1: back-to-back read
        do_read(32'h0000_1234, l1, 16'hFFFF, 5);
        read_i = 0;
        tick();
        chk("t1_idle_resp", {255'b0, resp_o}, '0);

        // 2: writeback
        do_write(32'h0000_5678, l2);

        // 3: read with resp_i gaps 1,0,0,1,1,0,1
        do_read(32'h8000_00FF, l3, 16'h0059, 8);
        read_i = 0;
        tick();

        // 4: async reset after beat 2 of a read
        address_i = 32'h0000_4000;
        read_i = 1;
        tick();
        tick();
        resp_i = 1;
        burst_i = 64'hAAAA_0000_0000_0001;
        tick();
        burst_i = 64'hAAAA_0000_0000_0002;
        tick();
        resp_i = 0;
        #2 rst = 0;
        #1;
        chk("arst_line_o", line_o, '0);
        chk("arst_read_o", {255'b0, read_o}, '0);
        chk("arst_resp_o", {255'b0, resp_o}, '0);
        chk("arst_address_o", {224'b0, address_o}, '0);
        chk("arst_burst_o", {192'b0, burst_o}, '0);
        read_i = 0;
        cur_line = '0;
        tick();
        rst = 1;
        tick();
        chk("arst_idle_read_o", {255'b0, read_o}, '0);
        chk("arst_idle_resp_o", {255'b0, resp_o}, '0);
        do_read(32'h0000_4000, l4, 16'hFFFF, 5);
        read_i = 0;
        tick();

        // 5a: read_i held through DONE, dropped in IDLE -> no second burst
        do_read(32'h0000_1234, l1, 16'hFFFF, 5);
        tick();
        chk("hold_idle_resp", {255'b0, resp_o}, '0);
        chk("hold_idle_read_o", {255'b0, read_o}, '0);
        read_i = 0;
        tick();
        chk("hold_no_rearm", {255'b0, read_o}, '0);

        // 5b: read_i still high in IDLE -> second burst starts
        do_read(32'h0000_2000, l3, 16'hFFFF, 5);
        tick();
        chk("rearm_idle_read_o", {255'b0, read_o}, '0);
        do_read(32'h0000_3000, l2, 16'hFFFF, 5);
        read_i = 0;
        tick();

        // 6: spurious resp_i in IDLE
        resp_i = 1;
        burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < 3; i++) tick();
        resp_i = 0;
        chk("spur_line_o", line_o, cur_line);
        chk("spur_read_o", {255'b0, read_o}, '0);
        chk("spur_write_o", {255'b0, write_o}, '0);
        chk("spur_resp_o", {255'b0, resp_o}, '0);
        tick();

        chk("line_queue_empty", 256'(exp_line.size()), '0);
        chk("burst_queue_empty", 256'(exp_burst.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
